// File: rtl/debug_value_sched_if.sv
// Bus between the debug value scheduler and its neighbours: button levels and
// scan position in, bulk load handshake, displayed value and status out.
interface debug_value_sched_if #(
    parameter int NUM_DIGITS = 16
);
    localparam int W = 4 * NUM_DIGITS;

    logic [NUM_DIGITS-1:0] btns;
    logic [9:0]            x_pos;
    logic [9:0]            y_pos;

    // Load handshake: a transfer happens on every rising vga_clk edge where
    // load_valid && load_ready. Once raised, load_valid and load_data are held
    // stable by the source until that edge; load_ready may drop at any time and
    // carries no commitment while load_valid is low.
    logic                  load_valid;
    logic [W-1:0]          load_data;
    logic                  load_ready;

    logic [W-1:0]          disp_value;
    logic                  frame_tick;
    logic                  busy;
    // Current scheduler state: 0 IDLE, 1 SCAN, 2 WAIT_VB, 3 COMMIT.
    logic [1:0]            dbg_state;

    modport master (
        output btns, x_pos, y_pos, load_valid, load_data,
        input  load_ready, disp_value, frame_tick, busy, dbg_state
    );

    modport slave (
        input  btns, x_pos, y_pos, load_valid, load_data,
        output load_ready, disp_value, frame_tick, busy, dbg_state
    );
endinterface

// File: rtl/debug_value_sched.sv
// Owns the hex value shown on the debug page. Button presses become per-digit
// increment requests, a bulk load overwrites the whole value, and all changes
// land in a working copy that is copied to the displayed value only during
// vertical blanking.
module debug_value_sched #(
    parameter int                      NUM_DIGITS  = 16,
    parameter int                      V_ACTIVE    = 480,
    parameter logic [4*NUM_DIGITS-1:0] RESET_VALUE = (4*NUM_DIGITS)'(64'h1234)
) (
    input  logic               vga_clk,
    input  logic               vga_rst,
    debug_value_sched_if.slave bus
);
    localparam int              W          = 4 * NUM_DIGITS;
    localparam int              IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [9:0]      V_ACTIVE_Y = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        WAIT_VB = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [NUM_DIGITS-1:0] btn_s1;
    logic [NUM_DIGITS-1:0] btn_s2;
    logic [NUM_DIGITS-1:0] btn_s3;
    logic [NUM_DIGITS-1:0] btn_edge;
    logic [NUM_DIGITS-1:0] pending;
    logic [NUM_DIGITS-1:0] pending_nxt;
    logic [W-1:0]          work;
    logic [W-1:0]          work_nxt;
    logic [W-1:0]          disp_q;
    logic                  frame_tick_q;
    logic                  busy_q;
    logic                  commit_req;
    logic                  vblank;
    logic                  vblank_q;
    logic                  vb_rise;
    logic                  load_accept;
    logic                  unused_x_pos;

    // The renderer owns the column position; it does not affect scheduling.
    assign unused_x_pos = ^bus.x_pos;

    assign vblank      = (bus.y_pos >= V_ACTIVE_Y);
    assign vb_rise     = vblank && !vblank_q;
    assign btn_edge    = btn_s2 & ~btn_s3;
    assign load_accept = bus.load_valid && (state == IDLE);

    assign bus.load_ready = (state == IDLE);
    assign bus.disp_value = disp_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.busy       = busy_q;
    assign bus.dbg_state  = state;

    // Two-flop synchroniser plus one history flop per button, and the
    // registered blanking level used to find the start of blanking.
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_s3   <= '0;
            vblank_q <= 1'b0;
        end else begin
            btn_s1   <= bus.btns;
            btn_s2   <= btn_s1;
            btn_s3   <= btn_s2;
            vblank_q <= vblank;
        end
    end

    // Next working value and request set: the scanned digit consumes its
    // request first, a load replaces everything, and fresh edges are OR-ed in
    // last so a press arriving in the same cycle is never lost.
    always_comb begin
        work_nxt    = work;
        pending_nxt = pending;
        if ((state == SCAN) && pending[idx]) begin
            work_nxt[{idx, 2'b00} +: 4] = work[{idx, 2'b00} +: 4] + 4'd1;
            pending_nxt[idx]            = 1'b0;
        end
        if (load_accept) begin
            work_nxt    = bus.load_data;
            pending_nxt = '0;
        end
        pending_nxt = pending_nxt | btn_edge;
    end

    // Scheduler. The display copy and frame_tick are loaded on the transition
    // into COMMIT so that both are visible during the COMMIT cycle itself.
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            state        <= IDLE;
            idx          <= '0;
            work         <= RESET_VALUE;
            pending      <= '0;
            disp_q       <= RESET_VALUE;
            frame_tick_q <= 1'b0;
            busy_q       <= 1'b0;
            commit_req   <= 1'b0;
        end else begin
            work         <= work_nxt;
            pending      <= pending_nxt;
            frame_tick_q <= 1'b0;
            if (load_accept) begin
                commit_req <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (vb_rise && ((|pending) || commit_req || load_accept)) begin
                        state  <= SCAN;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx == IDX_LAST) begin
                        if (vblank) begin
                            state        <= COMMIT;
                            disp_q       <= work_nxt;
                            frame_tick_q <= 1'b1;
                            commit_req   <= 1'b0;
                        end else begin
                            state <= WAIT_VB;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                WAIT_VB: begin
                    if (vb_rise) begin
                        state        <= COMMIT;
                        disp_q       <= work;
                        frame_tick_q <= 1'b1;
                        commit_req   <= 1'b0;
                    end
                end
                COMMIT: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_value_sched.sv
// Bench for debug_value_sched: a compressed raster (rows 400..479 active,
// then a configurable number of blanking rows), directed scenarios with
// literal expectations, and a randomized phase checked every cycle against a
// frame-level model of the digit scheduler.
`timescale 1ns/1ps
module tb_debug_value_sched;
    localparam int          ND       = 16;
    localparam int          V_ACTIVE = 480;
    localparam logic [63:0] RST_VAL  = 64'h1234;

    logic vga_clk = 1'b0;
    logic vga_rst = 1'b1;

    debug_value_sched_if #(.NUM_DIGITS(ND)) bus();

    debug_value_sched #(
        .NUM_DIGITS (ND),
        .V_ACTIVE   (V_ACTIVE),
        .RESET_VALUE(RST_VAL)
    ) dut (
        .vga_clk(vga_clk),
        .vga_rst(vga_rst),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    always #5 vga_clk = ~vga_clk;

    int n_vec     = 0;
    int n_err     = 0;
    int n_ticks   = 0;
    int cyc       = 0;
    int frame_cnt = 0;
    int vbr_cyc   = 0;
    int vb_len    = 45;
    bit rand_vb   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // ---------------- raster generator ----------------
    initial begin
        bus.y_pos = 10'd400;
        bus.x_pos = 10'd0;
        forever begin
            @(posedge vga_clk);
            cyc++;
            #1;
            if (int'(bus.y_pos) >= V_ACTIVE + vb_len - 1) begin
                bus.y_pos = 10'd400;
                if (rand_vb) begin
                    case ($urandom_range(0, 3))
                        0:       vb_len = 8;
                        1:       vb_len = 16;
                        2:       vb_len = 17;
                        default: vb_len = 45;
                    endcase
                end
            end else begin
                bus.y_pos = bus.y_pos + 10'd1;
            end
            if (bus.y_pos == 10'(V_ACTIVE)) begin
                frame_cnt++;
                vbr_cyc = cyc;
            end
            bus.x_pos = 10'($urandom_range(0, 799));
        end
    end

    // ---------------- reference model ----------------
    // Requests become visible three cycles after a pin rise. A scan started at
    // the blanking-start cycle t0 visits digit i in cycle t0+1+i; the result is
    // shown from cycle t0+ND+1 if blanking still holds in the last scan cycle,
    // otherwise from one cycle after the next blanking start.
    logic [3:0]    m_dig [ND];
    logic [ND-1:0] m_req, m_h1, m_h2, m_h3;
    logic [63:0]   m_disp, m_snap;
    bit            m_active, m_creq, m_vb_q;
    int            m_t0, m_commit;

    function automatic logic [63:0] pack_dig();
        logic [63:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = RST_VAL[4*i +: 4];
        m_req    = '0;
        m_h1     = '0;
        m_h2     = '0;
        m_h3     = '0;
        m_disp   = RST_VAL;
        m_snap   = RST_VAL;
        m_active = 1'b0;
        m_creq   = 1'b0;
        m_vb_q   = 1'b0;
        m_t0     = 0;
        m_commit = -1;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge vga_clk) begin
        bit            vb, vbr, exp_tick, exp_busy, any_req;
        logic [ND-1:0] edges;
        int            d;
        if (vga_rst) begin
            model_reset();
            check("rst_disp",  bus.disp_value, RST_VAL);
            check("rst_tick",  64'(bus.frame_tick), 64'd0);
            check("rst_busy",  64'(bus.busy), 64'd0);
            check("rst_ready", 64'(bus.load_ready), 64'd1);
            check("rst_state", 64'(bus.dbg_state), 64'd0);
        end else begin
            vb       = (int'(bus.y_pos) >= V_ACTIVE);
            vbr      = vb && !m_vb_q;
            edges    = m_h2 & ~m_h3;
            exp_tick = m_active && (cyc == m_commit);
            exp_busy = m_active && (cyc > m_t0);
            if (exp_tick) m_disp = m_snap;
            check("disp",  bus.disp_value, m_disp);
            check("tick",  64'(bus.frame_tick), 64'(exp_tick));
            check("busy",  64'(bus.busy), 64'(exp_busy));
            check("ready", 64'(bus.load_ready), 64'(!exp_busy));
            if (m_active) begin
                d = cyc - m_t0 - 1;
                if (d >= 0 && d < ND) begin
                    if (m_req[d]) begin
                        m_dig[d] = m_dig[d] + 4'd1;
                        m_req[d] = 1'b0;
                    end
                    if (d == ND - 1) begin
                        m_snap = pack_dig();
                        if (vb) m_commit = cyc + 1;
                    end
                end else if (d >= ND && m_commit < 0 && vbr) begin
                    m_commit = cyc + 1;
                end
                if (exp_tick) begin
                    m_active = 1'b0;
                    m_creq   = 1'b0;
                end
            end else begin
                any_req = |m_req;
                if (bus.load_valid) begin
                    for (int i = 0; i < ND; i++) m_dig[i] = bus.load_data[4*i +: 4];
                    m_req  = '0;
                    m_creq = 1'b1;
                end
                if (vbr && (any_req || m_creq)) begin
                    m_active = 1'b1;
                    m_t0     = cyc;
                    m_commit = -1;
                end
            end
            m_req  = m_req | edges;
            m_h3   = m_h2;
            m_h2   = m_h1;
            m_h1   = bus.btns;
            m_vb_q = vb;
        end
        if (bus.frame_tick) n_ticks++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        vga_rst        = 1'b1;
        bus.btns       = '0;
        bus.load_valid = 1'b0;
        tick();
        tick();
        vga_rst = 1'b0;
    endtask

    task automatic press(input int i, input int len);
        tick();
        bus.btns[i] = 1'b1;
        repeat (len) tick();
        bus.btns[i] = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int target = frame_cnt + n;
        int guard  = 0;
        while (frame_cnt < target && guard < n * 400) begin
            @(negedge vga_clk);
            guard++;
        end
        check("wait_frames", 64'(frame_cnt >= target), 64'd1);
    endtask

    task automatic wait_y(input int v);
        int guard = 0;
        @(negedge vga_clk);
        while (int'(bus.y_pos) != v && guard < 400) begin
            @(negedge vga_clk);
            guard++;
        end
        check("wait_y", 64'(bus.y_pos), 64'(v));
    endtask

    task automatic at_cycle(input int c);
        int guard = 0;
        @(negedge vga_clk);
        while (cyc < c && guard < 5000) begin
            @(negedge vga_clk);
            guard++;
        end
        check("at_cycle", 64'(cyc), 64'(c));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t, t0, b;
        bit acc;
        bus.btns       = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        model_reset();
        do_reset();

        // 1: idle frames leave the value alone and never tick
        wait_frames(2);
        at_cycle(cyc + 25);
        check("t1_disp", bus.disp_value, 64'h1234);
        check("t1_ticks", 64'(n_ticks), 64'd0);

        // 2: one-cycle press on digit 0 shows up exactly ND+1 cycles after blanking starts
        wait_y(420);
        press(0, 1);
        t0 = n_ticks;
        wait_frames(1);
        t = cyc;
        at_cycle(t + ND);
        check("t2_before", bus.disp_value, 64'h1234);
        at_cycle(t + ND + 1);
        check("t2_after", bus.disp_value, 64'h1235);
        check("t2_tick", 64'(bus.frame_tick), 64'd1);
        wait_frames(1);
        check("t2_ticks", 64'(n_ticks - t0), 64'd1);

        // 3: holding a button over several frames increments once
        do_reset();
        t0 = n_ticks;
        tick();
        bus.btns[3] = 1'b1;
        wait_frames(3);
        tick();
        bus.btns[3] = 1'b0;
        wait_frames(1);
        at_cycle(cyc + 25);
        check("t3_disp", bus.disp_value, 64'h2234);
        check("t3_ticks", 64'(n_ticks - t0), 64'd1);

        // 4: sixteen presses on the top digit wrap it back to its start
        do_reset();
        t0 = n_ticks;
        for (int p = 1; p <= 16; p++) begin
            wait_y(420);
            press(15, 1);
            wait_frames(1);
            at_cycle(cyc + ND + 2);
            if (p == 1)  check("t4_first", bus.disp_value, 64'h1000_0000_0000_1234);
            if (p == 15) check("t4_wrapF", bus.disp_value, 64'hF000_0000_0000_1234);
        end
        check("t4_final", bus.disp_value, 64'h1234);
        check("t4_ticks", 64'(n_ticks - t0), 64'd16);

        // 5: load in IDLE with a digit-0 edge in the same cycle keeps that request
        do_reset();
        wait_y(420);
        tick();
        bus.btns[0] = 1'b1;
        tick();
        bus.btns[0] = 1'b0;
        tick();
        bus.load_valid = 1'b1;
        bus.load_data  = 64'hDEAD_BEEF_0000_0000;
        tick();
        bus.load_valid = 1'b0;
        wait_frames(1);
        at_cycle(cyc + ND + 2);
        check("t5_disp", bus.disp_value, 64'hDEAD_BEEF_0000_0001);

        // 6: reset in the middle of a scan discards the pending update
        do_reset();
        wait_y(420);
        press(2, 1);
        wait_frames(1);
        t = cyc;
        at_cycle(t + 5);
        tick();
        vga_rst = 1'b1;
        tick();
        tick();
        vga_rst = 1'b0;
        t0 = n_ticks;
        @(negedge vga_clk);
        check("t6_disp", bus.disp_value, 64'h1234);
        check("t6_busy", 64'(bus.busy), 64'd0);
        wait_frames(1);
        at_cycle(cyc + 25);
        check("t6_ticks", 64'(n_ticks - t0), 64'd0);
        check("t6_disp2", bus.disp_value, 64'h1234);

        // 7: blanking too short for the scan defers the commit to the next blanking
        do_reset();
        wait_y(420);
        vb_len = 8;
        press(5, 1);
        wait_frames(1);
        t = cyc;
        at_cycle(t + ND + 1);
        check("t7_held", bus.disp_value, 64'h1234);
        check("t7_busy", 64'(bus.busy), 64'd1);
        wait_frames(1);
        t = cyc;
        at_cycle(t + 1);
        check("t7_disp", bus.disp_value, 64'h0010_1234);
        check("t7_tick", 64'(bus.frame_tick), 64'd1);
        vb_len = 45;

        // 8: load in the blanking-start cycle is taken and scanned immediately
        do_reset();
        wait_y(479);
        tick();
        t = cyc;
        bus.load_valid = 1'b1;
        bus.load_data  = 64'hCAFE_F00D_0123_4567;
        tick();
        bus.load_valid = 1'b0;
        @(negedge vga_clk);
        check("t8_busy", 64'(bus.busy), 64'd1);
        at_cycle(t + ND + 1);
        check("t8_disp", bus.disp_value, 64'hCAFE_F00D_0123_4567);
        check("t8_tick", 64'(bus.frame_tick), 64'd1);

        // 9: random buttons, loads and blanking lengths against the model
        rand_vb = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge vga_clk);
            acc = bus.load_valid && bus.load_ready;
            tick();
            if (acc) begin
                bus.load_valid = 1'b0;
            end else if (!bus.load_valid && $urandom_range(0, 299) == 0) begin
                bus.load_valid = 1'b1;
                bus.load_data  = {$urandom(), $urandom()};
            end
            if ($urandom_range(0, 15) == 0) begin
                b = int'($urandom_range(0, ND - 1));
                bus.btns[b] = ~bus.btns[b];
            end
        end
        bus.btns = '0;
        for (int g = 0; g < 2000 && bus.load_valid; g++) begin
            @(negedge vga_clk);
            acc = bus.load_ready;
            tick();
            if (acc) bus.load_valid = 1'b0;
        end
        check("t9_load_drained", 64'(bus.load_valid), 64'd0);
        rand_vb = 1'b0;
        vb_len  = 45;
        wait_frames(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        n_err++;
        $display("FAIL watchdog: simulation ran past %0d cycles, required completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
